imm_insert: RTL
===============

Name: imm_insert

Overview:
- Inverse of the immediate-extend path: packs a 32-bit signed immediate into the scattered RV32I immediate bit positions of a template instruction word.
- Checks that the immediate is in range and aligned for the selected format.
- Sits between the test/boot instruction generator and the instruction-memory write port.
- Valid/ready on both sides, 2-entry output buffer, sticky error counter.

Parameters:
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_imm  in  32  signed immediate, byte offset for B/J.
- in_tmpl  in  32  template instruction; non-immediate bits pass through unchanged.
- in_ImmSrc  in  2  format: 00 I, 01 S, 10 B, 11 J (same encoding as the immediate-extend decode).
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts word.
- out_instr  out  32  assembled instruction.
- out_err  out  1  range/alignment error for this word.
- err_count  out  ERRCNT_W  number of erroneous requests accepted, saturating.

Behaviour:
- Transfer occurs when valid&&ready on a side in the same cycle.
- Reset (rst_n=0 at clk edge): FIFO emptied, in_ready=0 during reset and 1 the cycle after, out_valid=0, out_instr=0, out_err=0, err_count=0. Reset mid-transfer drops all buffered words; nothing is emitted afterwards.
- Field placement; bits outside these positions come from in_tmpl:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Error rules:
  - I/S: error if imm[31:11] not all equal.
  - B: error if imm[31:12] not all equal or imm[0]=1.
  - J: error if imm[31:20] not all equal or imm[0]=1.
- On error the word is still assembled from the truncated bits, and out_err=1 accompanies it.
- Buffer:
  - 2-entry FIFO of {instr, err}, combinational encode into the write side.
  - Latency: request accepted at edge N is visible on out_valid/out_instr after edge N, i.e. the next cycle, if the FIFO was empty.
- Flow control:
  - in_ready = !full, from registered occupancy only; no combinational path from out_ready.
  - out_valid = !empty.
  - out_instr/out_err hold stable while out_valid&&!out_ready.
- Simultaneous events:
  - Push and pop in the same cycle at occupancy 1: occupancy stays 1, order preserved.
  - At occupancy 2 no push is possible (in_ready=0), even if a pop occurs that cycle.
  - Read and write pointers are 1 bit each and wrap.
- err_count increments on each accepted request with error and saturates at all-ones.

Optional Feature:
- Macro IMM_INSERT_DROP_EN.
- Defined: erroneous requests are consumed (in_ready as normal) and counted in err_count, but not written to the FIFO; out_err is tied to 0.
- Undefined: behaviour as above; erroneous words are emitted flagged.

Test Plan:
- I-type: imm=0xFFFFF800, ImmSrc=00, tmpl=0x00000013, out_ready=1 -> next cycle out_instr=0x80000013, out_err=0.
- S-type: imm=0x000007FF, ImmSrc=01, tmpl=0x00002023 -> out_instr=0x7E002FA3, err=0.
- B and J:
  - B: imm=0xFFFFFFFC, ImmSrc=10, tmpl=0x00000063 -> 0xFE000EE3.
  - J: imm=0x00000800, ImmSrc=11, tmpl=0x0000006F -> 0x0010006F.
  - Both with err=0.
- Errors:
  - B imm=0x00000003 -> out_err=1, err_count=1.
  - I imm=0x00000800 -> out_err=1, err_count=2.
  - With IMM_INSERT_DROP_EN: no output words, err_count=2.
- Backpressure:
  - Hold out_ready=0 and offer 3 requests (I imm 1,2,3, tmpl=0x13) -> in_ready=0 after two accepts, third held stable.
  - Then release out_ready -> outputs 0x00100013, 0x00200013, 0x00300013 in order.
- Reset mid-stream: two words buffered, assert rst_n=0 for one edge -> out_valid=0, err_count=0; in_ready=1 the next cycle; no stale words emitted.

Source files
------------

// File: rtl/imm_insert.sv
// +--------------------------------------------------------------------------+
// | imm_insert: packs a signed immediate into an RV32I template word, with     |
// | a range/alignment check, 2-entry output FIFO and a saturating error count. |
// | Optional IMM_INSERT_DROP_EN: erroneous requests are counted, not emitted.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_insert #(
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_tmpl,
  input  logic [1:0]          in_ImmSrc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [1:0] c_FMT_I = 2'b00;
  localparam logic [1:0] c_FMT_S = 2'b01;
  localparam logic [1:0] c_FMT_B = 2'b10;
  localparam logic [1:0] c_FMT_J = 2'b11;

`ifdef IMM_INSERT_DROP_EN
  localparam int c_ENTRY_W = 32;
`else
  localparam int c_ENTRY_W = 33;
`endif

  logic [31:0]          w_instr;
  logic                 w_err;
  logic [c_ENTRY_W-1:0] w_entry;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;

  logic [c_ENTRY_W-1:0] r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic [ERRCNT_W-1:0]  r_err_count;

  // The error test is "upper bits are a pure sign extension" over the field width.
  always_comb begin
    w_instr = in_tmpl;
    w_err   = 1'b0;
    case (in_ImmSrc)
      c_FMT_I: begin
        w_instr[31:20] = in_imm[11:0];
        w_err          = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      c_FMT_S: begin
        w_instr[31:25] = in_imm[11:5];
        w_instr[11:7]  = in_imm[4:0];
        w_err          = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      c_FMT_B: begin
        w_instr[31]    = in_imm[12];
        w_instr[7]     = in_imm[11];
        w_instr[30:25] = in_imm[10:5];
        w_instr[11:8]  = in_imm[4:1];
        w_err          = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      end
      c_FMT_J: begin
        w_instr[31]    = in_imm[20];
        w_instr[30:21] = in_imm[10:1];
        w_instr[20]    = in_imm[11];
        w_instr[19:12] = in_imm[19:12];
        w_err          = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      end
      default: begin
        w_instr = in_tmpl;
        w_err   = 1'b0;
      end
    endcase
  end

  // in_ready looks only at stored occupancy, never at out_ready.
  assign w_full    = (r_count == 2'd2);
  assign in_ready  = rst_n && !w_full;
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign err_count = r_err_count;

`ifdef IMM_INSERT_DROP_EN
  assign w_entry   = w_instr;
  assign w_push    = w_accept && !w_err;
  assign out_instr = r_mem[r_rd_ptr];
  assign out_err   = 1'b0;
`else
  assign w_entry   = {w_instr, w_err};
  assign w_push    = w_accept;
  assign out_instr = r_mem[r_rd_ptr][32:1];
  assign out_err   = r_mem[r_rd_ptr][0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_err_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_accept && w_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
